umi_regif_burst: RTL

- Next-generation UMI device-side register bridge, parametrised in register width and read latency.
- Accepts one UMI request at a time and splits multi-word requests (LEN > 0) into consecutive single-word register accesses.
- Packs read words into one UMI response; supports register-side back-pressure.
- Sits between a UMI device port (udev_req/udev_resp) and a register file or single-port SRAM.

---
 rtl/umi_regif_pkg.sv | 47 ++++
 rtl/umi_regif_rdpipe.sv | 40 ++++
 rtl/umi_regif_burst.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/umi_regif_pkg.sv
// umi_regif_pkg: shared UMI command-field layout, opcodes, FSM states and the
// response-command packing helper for the umi_regif_burst register bridge.
package umi_regif_pkg;

  // Request / response opcodes
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [4:0] REQ_POSTED = 5'h05;

  // Command field positions
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 5;
  localparam int SIZE_LSB = 5;
  localparam int SIZE_W   = 3;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 8;
  localparam int ERR_LSB  = 25;
  localparam int ERR_W    = 2;

  // Error code reported for unsupported requests
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNSUP = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Build a 32-bit UMI command word from its fields
  function automatic logic [31:0] cmd_pack(input logic [4:0] opcode,
                                           input logic [2:0] size,
                                           input logic [7:0] len,
                                           input logic [1:0] err);
    logic [31:0] cmd;
    cmd = 32'd0;
    cmd[OPC_LSB  +: OPC_W]  = opcode;
    cmd[SIZE_LSB +: SIZE_W] = size;
    cmd[LEN_LSB  +: LEN_W]  = len;
    cmd[ERR_LSB  +: ERR_W]  = err;
    return cmd;
  endfunction

endpackage

// File: rtl/umi_regif_rdpipe.sv
// umi_regif_rdpipe: turns an accepted register read into a one-cycle sample
// strobe RDLAT cycles later. With RDLAT=0 the strobe coincides with the accept.
module umi_regif_rdpipe #(
  parameter int RDLAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic sample_o
);

  localparam logic [2:0] LAT = 3'(RDLAT);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Load the latency on accept, then count down to the sample cycle
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LAT;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Countdown register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_o = (LAT == 3'd0) ? start_i : (cnt_q == 3'd1);

endmodule

// File: rtl/umi_regif_burst.sv
// umi_regif_burst: UMI device-port to register-file bridge. Splits LEN>0
// requests into single-word register accesses and packs read words into one
// response. Optional macro UMI_REGIF_ERR_EN: unsupported READ/WRITE requests
// return an error response instead of being consumed silently.
module umi_regif_burst
  import umi_regif_pkg::*;
#(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int RW    = 32,
  parameter int RDLAT = 1,
  parameter int MAXW  = DW / RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic [AW-1:0] reg_addr,
  output logic          reg_write,
  output logic          reg_read,
  output logic [RW-1:0] reg_wrdata,
  input  logic          reg_ready,
  input  logic [RW-1:0] reg_rddata
);

  localparam int         BYTES   = RW / 8;
  localparam logic [2:0] SIZE_OK = 3'($clog2(RW / 8));

  state_e        state_q, state_d;
  logic [4:0]    opc_q, opc_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    len_q, len_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    idx_q, idx_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;

  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [CW-1:0] resp_cmd_q, resp_cmd_d;
  logic [AW-1:0] resp_dst_q, resp_dst_d;
  logic [AW-1:0] resp_src_q, resp_src_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic          reg_write_q, reg_write_d;
  logic          reg_read_q, reg_read_d;
  logic [RW-1:0] reg_wrdata_q, reg_wrdata_d;

  logic [4:0] opc_in_s;
  logic       req_ok_s;
  logic       last_s;
  logic       start_s;
  logic       sample_s;
  logic       unused_cmd_s;

  assign opc_in_s = udev_req_cmd[OPC_LSB +: OPC_W];
  assign req_ok_s = ((opc_in_s == REQ_READ) || (opc_in_s == REQ_WRITE) ||
                     (opc_in_s == REQ_POSTED)) &&
                    (udev_req_cmd[SIZE_LSB +: SIZE_W] == SIZE_OK) &&
                    (32'(udev_req_cmd[LEN_LSB +: LEN_W]) < 32'(MAXW));
  assign last_s       = (idx_q == len_q);
  assign start_s      = (state_q == ACCESS) && reg_read_q && reg_ready;
  assign unused_cmd_s = ^udev_req_cmd[CW-1:16];

  umi_regif_rdpipe #(.RDLAT(RDLAT)) u_rdpipe (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_s),
    .sample_o(sample_s)
  );

  // Next-state, capture and word-sequencing logic
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    size_d  = size_q;
    len_d   = len_q;
    err_d   = err_q;
    idx_d   = idx_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (udev_req_valid && req_ready_q) begin
          opc_d  = opc_in_s;
          size_d = udev_req_cmd[SIZE_LSB +: SIZE_W];
          len_d  = udev_req_cmd[LEN_LSB +: LEN_W];
          err_d  = ERR_NONE;
          dst_d  = udev_req_dstaddr;
          src_d  = udev_req_srcaddr;
          idx_d  = 8'd0;
          // Read requests reuse the data buffer for returned words
          data_d = (opc_in_s == REQ_READ) ? {DW{1'b0}} : udev_req_data;
          if (req_ok_s) begin
            state_d = ACCESS;
          end else begin
`ifdef UMI_REGIF_ERR_EN
            if ((opc_in_s == REQ_READ) || (opc_in_s == REQ_WRITE)) begin
              state_d = RESP;
              err_d   = ERR_UNSUP;
              data_d  = {DW{1'b0}};
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (reg_ready) begin
          if (opc_q == REQ_READ) begin
            if (sample_s) begin
              data_d[idx_q*RW +: RW] = reg_rddata;
              if (last_s) begin
                state_d = RESP;
              end else begin
                idx_d   = idx_q + 8'd1;
                state_d = ACCESS;
              end
            end else begin
              state_d = WAIT;
            end
          end else if (last_s) begin
            state_d = (opc_q == REQ_POSTED) ? IDLE : RESP;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ACCESS;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      WAIT: begin
        if (sample_s) begin
          data_d[idx_q*RW +: RW] = reg_rddata;
          if (last_s) begin
            state_d = RESP;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ACCESS;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (udev_resp_ready && resp_valid_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    reg_write_d  = 1'b0;
    reg_read_d   = 1'b0;
    reg_addr_d   = {AW{1'b0}};
    reg_wrdata_d = {RW{1'b0}};
    resp_valid_d = 1'b0;
    resp_cmd_d   = {CW{1'b0}};
    resp_dst_d   = {AW{1'b0}};
    resp_src_d   = {AW{1'b0}};
    resp_data_d  = {DW{1'b0}};
    if (state_d == ACCESS) begin
      reg_read_d  = (opc_d == REQ_READ);
      reg_write_d = (opc_d != REQ_READ);
      // Byte address wraps modulo 2^AW
      reg_addr_d  = dst_d + (AW'(idx_d) * AW'(BYTES));
      if (opc_d != REQ_READ) begin
        reg_wrdata_d = data_d[idx_d*RW +: RW];
      end else begin
        reg_wrdata_d = {RW{1'b0}};
      end
    end else begin
      reg_read_d = 1'b0;
    end
    if (state_d == RESP) begin
      resp_valid_d = 1'b1;
      resp_cmd_d   = CW'(cmd_pack((opc_d == REQ_READ) ? RESP_READ : RESP_WRITE,
                                  size_d, len_d, err_d));
      resp_dst_d   = src_d;
      resp_src_d   = dst_d;
      resp_data_d  = (opc_d == REQ_READ) ? data_d : {DW{1'b0}};
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      opc_q        <= 5'd0;
      size_q       <= 3'd0;
      len_q        <= 8'd0;
      err_q        <= ERR_NONE;
      idx_q        <= 8'd0;
      dst_q        <= {AW{1'b0}};
      src_q        <= {AW{1'b0}};
      data_q       <= {DW{1'b0}};
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= {CW{1'b0}};
      resp_dst_q   <= {AW{1'b0}};
      resp_src_q   <= {AW{1'b0}};
      resp_data_q  <= {DW{1'b0}};
      reg_addr_q   <= {AW{1'b0}};
      reg_write_q  <= 1'b0;
      reg_read_q   <= 1'b0;
      reg_wrdata_q <= {RW{1'b0}};
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      size_q       <= size_d;
      len_q        <= len_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_cmd_q   <= resp_cmd_d;
      resp_dst_q   <= resp_dst_d;
      resp_src_q   <= resp_src_d;
      resp_data_q  <= resp_data_d;
      reg_addr_q   <= reg_addr_d;
      reg_write_q  <= reg_write_d;
      reg_read_q   <= reg_read_d;
      reg_wrdata_q <= reg_wrdata_d;
    end
  end

  assign udev_req_ready    = req_ready_q;
  assign udev_resp_valid   = resp_valid_q;
  assign udev_resp_cmd     = resp_cmd_q;
  assign udev_resp_dstaddr = resp_dst_q;
  assign udev_resp_srcaddr = resp_src_q;
  assign udev_resp_data    = resp_data_q;
  assign reg_addr          = reg_addr_q;
  assign reg_write         = reg_write_q;
  assign reg_read          = reg_read_q;
  assign reg_wrdata        = reg_wrdata_q;

endmodule
